// File: rtl/hash_table_uram_stage.sv
`default_nettype none
// ============================================================================
//  Module      : hash_table_uram_stage
//  Description : Direct-mapped bucket table with SEARCH/INSERT/DELETE, one op
//                per cycle, two-edge latency, with write-to-read forwarding.
//  Revision    : 1.0 - initial release
// ============================================================================
module hash_table_uram_stage #(
    parameter int KEY_WIDTH   = 32,
    parameter int INDEX_WIDTH = 12,
    parameter int VALUE_WIDTH = 31
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en_in,
    input  logic [1:0]             opt_in,
    input  logic [INDEX_WIDTH-1:0] index,
    input  logic [KEY_WIDTH-1:0]   key_in,
    input  logic [VALUE_WIDTH-1:0] value_in,
    output logic                   ready,
    output logic                   en_out,
    output logic [1:0]             opt_out,
    output logic [KEY_WIDTH-1:0]   key_out,
    output logic [VALUE_WIDTH-1:0] value_out,
    output logic                   hit,
    output logic                   collision,
    output logic [INDEX_WIDTH:0]   occupancy
);

    localparam int                     c_depth     = 2 ** INDEX_WIDTH;
    localparam logic [INDEX_WIDTH-1:0] c_last_idx  = '1;
    localparam logic [INDEX_WIDTH:0]   c_occ_max   = (INDEX_WIDTH + 1)'(c_depth);
    localparam logic [1:0]             c_op_search = 2'b00;
    localparam logic [1:0]             c_op_insert = 2'b01;
    localparam logic [1:0]             c_op_delete = 2'b10;
    localparam logic [1:0]             c_op_nop    = 2'b11;

    typedef struct packed {
        logic                   valid;
        logic [KEY_WIDTH-1:0]   key;
        logic [VALUE_WIDTH-1:0] value;
    } entry_t;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   w_init_we;
    logic [INDEX_WIDTH-1:0] r_init_cnt;

    entry_t                 r_mem [c_depth];
    entry_t                 r_rd_q;

    logic                   r_p1_v;
    logic [1:0]             r_p1_opt;
    logic [INDEX_WIDTH-1:0] r_p1_idx;
    logic [KEY_WIDTH-1:0]   r_p1_key;
    logic [VALUE_WIDTH-1:0] r_p1_value;

    logic                   r_wr_v;
    logic [INDEX_WIDTH-1:0] r_wr_idx;
    entry_t                 r_wr_data;

    logic                   r_en_out;
    logic [1:0]             r_opt_out;
    logic [KEY_WIDTH-1:0]   r_key_out;
    logic [VALUE_WIDTH-1:0] r_value_out;
    logic                   r_hit;
    logic                   r_collision;
    logic [INDEX_WIDTH:0]   r_occupancy;

    logic                   w_accept;
    entry_t                 w_eff;
    logic                   w_match;
    logic                   w_op_we;
    entry_t                 w_op_wdata;
    logic                   w_hit;
    logic                   w_collision;
    logic [VALUE_WIDTH-1:0] w_value;
    logic                   w_occ_inc;
    logic                   w_occ_dec;
    logic                   w_mem_we;
    logic [INDEX_WIDTH-1:0] w_mem_addr;
    entry_t                 w_mem_wdata;

    // ------------------------------------------------------------------
    // Init / run control
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_init_we    = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_init_we = 1'b1;
                if (r_init_cnt == c_last_idx) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN:  w_state_next = ST_RUN;
            default: w_state_next = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_init_cnt <= '0;
        end else if (w_init_we) begin
            r_init_cnt <= r_init_cnt + INDEX_WIDTH'(1);
        end
    end

    assign ready    = (r_state == ST_RUN);
    assign w_accept = ready && en_in;

    // ------------------------------------------------------------------
    // Stage P1: capture op and issue the synchronous table read
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_p1_v     <= 1'b0;
            r_p1_opt   <= '0;
            r_p1_idx   <= '0;
            r_p1_key   <= '0;
            r_p1_value <= '0;
        end else begin
            r_p1_v     <= w_accept;
            r_p1_opt   <= opt_in;
            r_p1_idx   <= index;
            r_p1_key   <= key_in;
            r_p1_value <= value_in;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept && (opt_in != c_op_nop)) begin
            r_rd_q <= r_mem[index];
        end
    end

    // ------------------------------------------------------------------
    // Op evaluation; the read returns pre-write data when the previous op
    // wrote the same bucket, so that write is forwarded here.
    // ------------------------------------------------------------------
    always_comb begin
        w_eff       = (r_wr_v && (r_wr_idx == r_p1_idx)) ? r_wr_data : r_rd_q;
        w_match     = w_eff.valid && (w_eff.key == r_p1_key);
        w_op_we     = 1'b0;
        w_op_wdata  = '0;
        w_hit       = 1'b0;
        w_collision = 1'b0;
        w_value     = '0;
        w_occ_inc   = 1'b0;
        w_occ_dec   = 1'b0;
        if (r_p1_v) begin
            case (r_p1_opt)
                c_op_search: begin
                    w_hit = w_match;
                    if (w_match) begin
                        w_value = w_eff.value;
                    end
                end
                c_op_insert: begin
                    if (w_match || !w_eff.valid) begin
                        w_op_we    = 1'b1;
                        w_op_wdata = '{valid: 1'b1, key: r_p1_key, value: r_p1_value};
                        w_hit      = w_match;
                        w_occ_inc  = !w_match;
                    end else begin
                        w_collision = 1'b1;
                    end
                end
                c_op_delete: begin
                    if (w_match) begin
                        w_op_we   = 1'b1;
                        w_hit     = 1'b1;
                        w_occ_dec = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Stage E1: register results and remember the committed write
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_en_out    <= 1'b0;
            r_opt_out   <= '0;
            r_key_out   <= '0;
            r_value_out <= '0;
            r_hit       <= 1'b0;
            r_collision <= 1'b0;
            r_occupancy <= '0;
            r_wr_v      <= 1'b0;
            r_wr_idx    <= '0;
            r_wr_data   <= '0;
        end else begin
            r_en_out    <= r_p1_v;
            r_opt_out   <= r_p1_opt;
            r_key_out   <= r_p1_key;
            r_value_out <= w_value;
            r_hit       <= w_hit;
            r_collision <= w_collision;
            r_wr_v      <= w_op_we;
            r_wr_idx    <= r_p1_idx;
            r_wr_data   <= w_op_wdata;
            if (w_occ_inc && (r_occupancy != c_occ_max)) begin
                r_occupancy <= r_occupancy + (INDEX_WIDTH + 1)'(1);
            end else if (w_occ_dec && (r_occupancy != '0)) begin
                r_occupancy <= r_occupancy - (INDEX_WIDTH + 1)'(1);
            end
        end
    end

    // Init sweep and op writes never coincide: no op is accepted during INIT.
    assign w_mem_we    = !reset && (w_init_we || w_op_we);
    assign w_mem_addr  = w_init_we ? r_init_cnt : r_p1_idx;
    assign w_mem_wdata = w_init_we ? entry_t'('0) : w_op_wdata;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    assign en_out    = r_en_out;
    assign opt_out   = r_opt_out;
    assign key_out   = r_key_out;
    assign value_out = r_value_out;
    assign hit       = r_hit;
    assign collision = r_collision;
    assign occupancy = r_occupancy;

endmodule
`default_nettype wire
